alu_result_pipe: RTL and testbench

ALU_RESULT_PIPE -- requirements
Module: alu_result_pipe

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_flags.sv | 52 +++++
 rtl/alu_result_pipe.sv | 135 +++++++++++++
 tb/tb_alu_result_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU result pipe:
//     - datapath width and flag-bit indices
//     - entry_t: packed record stored per buffered result
//       (result, destination tag, four condition flags)
//     - flag_vec(): packs the four flags into a vector at the fixed indices
//   The destination tag field is sized for the widest supported tag
//   (RD_MAX_W); users store their RD_W-bit tag in the low bits.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W    = 32;
    localparam int RD_MAX_W  = 16;
    localparam int N_FLAGS   = 4;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    typedef struct packed {
        logic [DATA_W-1:0]   result;
        logic [RD_MAX_W-1:0] rd;
        logic [N_FLAGS-1:0]  flags;
    } entry_t;

    function automatic logic [N_FLAGS-1:0] flag_vec(
        input logic zero,
        input logic neg,
        input logic carry,
        input logic ovf
    );
        logic [N_FLAGS-1:0] v;
        v             = '0;
        v[FLAG_ZERO]  = zero;
        v[FLAG_NEG]   = neg;
        v[FLAG_CARRY] = carry;
        v[FLAG_OVF]   = ovf;
        return v;
    endfunction

endpackage

// File: rtl/alu_flags.sv
// ---------------------------------------------------------------------------
// alu_flags
//   Purely combinational condition-flag generator for an add/sub result.
//   Ports:
//     result  in  32  sum/difference produced by the adder
//     op_a    in  32  adder operand A
//     op_b    in  32  adder operand B (un-inverted)
//     sub     in  1   1 = A-B, 0 = A+B
//     flags   out 4   zero/neg/carry/ovf at alu_pkg FLAG_* indices
//   FLAGS_EN = 0 ties every flag to 0.
// ---------------------------------------------------------------------------
module alu_flags
    import alu_pkg::*;
#(
    parameter bit FLAGS_EN = 1'b1
) (
    input  logic [DATA_W-1:0]  result,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    input  logic               sub,
    output logic [N_FLAGS-1:0] flags
);

    // Only the sign bits of the operands matter; the adder already folded
    // the low bits into the result.
    logic a31;
    logic b31_eff;
    logic r31;
    logic unused_operand_bits;

    assign a31     = op_a[DATA_W-1];
    assign b31_eff = sub ? ~op_b[DATA_W-1] : op_b[DATA_W-1];
    assign r31     = result[DATA_W-1];

    assign unused_operand_bits = ^{op_a[DATA_W-2:0], op_b[DATA_W-2:0]};

    always_comb begin
        flags = '0;
        if (FLAGS_EN) begin
            // Carry out of bit 31 rebuilt from the MSBs: generate, or
            // propagate with no carry visible in the result bit. For a
            // subtract (A + ~B + 1) this is the "no borrow" indication.
            flags = flag_vec(
                (result == '0),
                r31,
                (a31 & b31_eff) | ((a31 | b31_eff) & ~r31),
                (a31 == b31_eff) && (r31 != a31)
            );
        end
    end

endmodule

// File: rtl/alu_result_pipe.sv
// ---------------------------------------------------------------------------
// alu_result_pipe
//   Two-entry skid buffer placed after the adder stage. Each accepted
//   result is tagged with its condition flags (computed on entry) and its
//   destination register, and delivered in arrival order.
//
//   Handshake: a transfer happens on a rising clk edge where valid and
//   ready are both 1 on that side. in_ready is a flop that is 1 exactly
//   when fewer than two entries are stored, so it never depends
//   combinationally on out_ready. Upstream must hold its data while
//   in_ready is 0; out_* hold steady while out_valid=1 and out_ready=0.
//
//   Ports:
//     clk, rst            clock, async active-high reset
//     in_valid/in_ready   upstream handshake
//     in_result, in_op_a, in_op_b, in_sub, in_rd   upstream payload
//     out_valid/out_ready downstream handshake
//     out_result, out_rd, out_zero/neg/carry/ovf   head-entry fields
//     occupancy           stored entries, 0..2
// ---------------------------------------------------------------------------
module alu_result_pipe
    import alu_pkg::*;
#(
    parameter int RD_W     = 5,    // must not exceed alu_pkg::RD_MAX_W
    parameter bit FLAGS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_op_a,
    input  logic [DATA_W-1:0] in_op_b,
    input  logic              in_sub,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_carry,
    output logic              out_ovf,
    output logic [1:0]        occupancy
);

    // head_q is always the oldest entry and drives out_*; tail_q holds the
    // second entry when two are stored.
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] occ_q, occ_d;
    logic       in_ready_q, in_ready_d;

    entry_t             in_entry;
    logic [N_FLAGS-1:0] in_flags;
    logic               push;
    logic               pop;
    logic               unused_rd_bits;

    alu_flags #(
        .FLAGS_EN (FLAGS_EN)
    ) u_flags (
        .result (in_result),
        .op_a   (in_op_a),
        .op_b   (in_op_b),
        .sub    (in_sub),
        .flags  (in_flags)
    );

    always_comb begin
        in_entry              = '0;
        in_entry.result       = in_result;
        in_entry.rd[RD_W-1:0] = in_rd;
        in_entry.flags        = in_flags;
    end

    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;

        if (pop) begin
            head_d = tail_q;
        end

        // New entry lands in the first free slot after this cycle's pop:
        // the head if the buffer is (or becomes) empty, otherwise the tail.
        if (push) begin
            if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
                head_d = in_entry;
            end else begin
                tail_d = in_entry;
            end
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        in_ready_d = (occ_d != 2'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign occupancy  = occ_q;
    assign out_result = head_q.result;
    assign out_rd     = head_q.rd[RD_W-1:0];
    assign out_zero   = head_q.flags[FLAG_ZERO];
    assign out_neg    = head_q.flags[FLAG_NEG];
    assign out_carry  = head_q.flags[FLAG_CARRY];
    assign out_ovf    = head_q.flags[FLAG_OVF];

    // Tag bits above RD_W are never written with anything but zero.
    assign unused_rd_bits = ^{head_q.rd, tail_q.rd};

endmodule

// File: tb/tb_alu_result_pipe.sv
module tb_alu_result_pipe;

    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [31:0]     in_result;
    logic [31:0]     in_op_a;
    logic [31:0]     in_op_b;
    logic            in_sub;
    logic [RD_W-1:0] in_rd;
    logic            out_ready;

    logic            o_in_ready, o_out_valid, o_zero, o_neg, o_carry, o_ovf;
    logic [31:0]     o_result;
    logic [RD_W-1:0] o_rd;
    logic [1:0]      o_occ;

    logic            z_in_ready, z_out_valid, z_zero, z_neg, z_carry, z_ovf;
    logic [31:0]     z_result;
    logic [RD_W-1:0] z_rd;
    logic [1:0]      z_occ;

    always #5 clk = ~clk;

    alu_result_pipe #(.RD_W(RD_W), .FLAGS_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(o_in_ready),
        .in_result(in_result), .in_op_a(in_op_a), .in_op_b(in_op_b),
        .in_sub(in_sub), .in_rd(in_rd),
        .out_valid(o_out_valid), .out_ready(out_ready),
        .out_result(o_result), .out_rd(o_rd),
        .out_zero(o_zero), .out_neg(o_neg), .out_carry(o_carry), .out_ovf(o_ovf),
        .occupancy(o_occ)
    );

    alu_result_pipe #(.RD_W(RD_W), .FLAGS_EN(1'b0)) dut_noflags (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(z_in_ready),
        .in_result(in_result), .in_op_a(in_op_a), .in_op_b(in_op_b),
        .in_sub(in_sub), .in_rd(in_rd),
        .out_valid(z_out_valid), .out_ready(out_ready),
        .out_result(z_result), .out_rd(z_rd),
        .out_zero(z_zero), .out_neg(z_neg), .out_carry(z_carry), .out_ovf(z_ovf),
        .occupancy(z_occ)
    );

    typedef struct {
        logic [31:0]     result;
        logic [RD_W-1:0] rd;
        logic            zero, neg, carry, ovf;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference: flags from the arithmetic meaning of the operation.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input bit sub, input logic [RD_W-1:0] rd);
        exp_t   e;
        longint ua, ub, sa, sb, s;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.result = sub ? a - b : a + b;
        e.rd     = rd;
        e.zero   = (e.result == 32'd0);
        e.neg    = e.result[31];
        if (sub) begin
            e.carry = (ua >= ub);
            s       = sa - sb;
        end else begin
            e.carry = ((ua + ub) > 64'sh0FFFF_FFFF);
            s       = sa + sb;
        end
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        int n;
        n = exp_q.size();
        check({tag, "_occ"},       o_occ,       n);
        check({tag, "_in_ready"},  o_in_ready,  (n < 2));
        check({tag, "_out_valid"}, o_out_valid, (n > 0));
        check({tag, "_nf_occ"},    z_occ,       n);
        check({tag, "_nf_flags"},  {z_zero, z_neg, z_carry, z_ovf}, 4'b0000);
        if (n > 0) begin
            check({tag, "_result"}, o_result, exp_q[0].result);
            check({tag, "_rd"},     o_rd,     exp_q[0].rd);
            check({tag, "_flags"},  {o_zero, o_neg, o_carry, o_ovf},
                  {exp_q[0].zero, exp_q[0].neg, exp_q[0].carry, exp_q[0].ovf});
            check({tag, "_nf_result"}, z_result, exp_q[0].result);
            check({tag, "_nf_rd"},     z_rd,     exp_q[0].rd);
        end
    endtask

    // Checks the current state, drives one cycle of stimulus, advances to
    // #1 after the edge and updates the reference queue.
    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input bit sub, input logic [RD_W-1:0] rd, input bit ordy,
                        input string tag);
        exp_t e;
        bit   do_push, do_pop;
        check_outputs(tag);
        e         = model(a, b, sub, rd);
        in_valid  = v;
        in_op_a   = a;
        in_op_b   = b;
        in_sub    = sub;
        in_result = e.result;
        in_rd     = rd;
        out_ready = ordy;
        do_push   = v && (exp_q.size() < 2);
        do_pop    = ordy && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop)  void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(e);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_op_a = '0; in_op_b = '0;
        in_sub = 1'b0; in_rd = '0; out_ready = 1'b0;
        #1;
        // Reset state
        check("rst_occ",      o_occ, 2'd0);
        check("rst_in_ready", o_in_ready, 1'b1);
        check("rst_valid",    o_out_valid, 1'b0);
        check("rst_result",   o_result, 32'd0);
        check("rst_rd",       o_rd, '0);
        check("rst_flags",    {o_zero, o_neg, o_carry, o_ovf}, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Add wrapping to zero: zero=1 carry=1 ovf=0 neg=0
        step(1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 5'd1, 1, "add_wrap");
        check("add_wrap_valid", o_out_valid, 1'b1);
        check("add_wrap_zncv",  {o_zero, o_neg, o_carry, o_ovf}, 4'b1010);
        // Sub with signed overflow: ovf=1 carry=1 neg=0
        step(1, 32'h8000_0000, 32'h0000_0001, 1, 5'd2, 1, "sub_ovf");
        check("sub_ovf_zncv",   {o_zero, o_neg, o_carry, o_ovf}, 4'b0011);
        check("sub_ovf_result", o_result, 32'h7FFF_FFFF);
        // Sub with borrow: carry=0 neg=1 ovf=0
        step(1, 32'h0000_0001, 32'h0000_0002, 1, 5'd3, 1, "sub_borrow");
        check("sub_borrow_zncv",   {o_zero, o_neg, o_carry, o_ovf}, 4'b0100);
        check("sub_borrow_result", o_result, 32'hFFFF_FFFF);
        step(0, 32'd0, 32'd0, 0, 5'd0, 1, "drain0");

        // Fill to two, third push ignored, then drain in order
        step(1, 32'd10, 32'd20, 0, 5'd3, 0, "fill_a");
        step(1, 32'd30, 32'd5,  1, 5'd4, 0, "fill_b");
        check("full_in_ready", o_in_ready, 1'b0);
        check("full_occ",      o_occ, 2'd2);
        step(1, 32'd7,  32'd7,  1, 5'd5, 0, "fill_ignored");
        step(1, 32'd7,  32'd7,  1, 5'd5, 0, "hold_stable");
        check("drain_first_rd", o_rd, 5'd3);
        step(0, 32'd0,  32'd0,  0, 5'd0, 1, "drain_a");
        check("drain_second_rd", o_rd, 5'd4);
        check("drain_in_ready",  o_in_ready, 1'b1);
        step(0, 32'd0,  32'd0,  0, 5'd0, 1, "drain_b");
        check("drained_valid", o_out_valid, 1'b0);

        // Steady push+pop at occupancy 1
        step(1, 32'd100, 32'd1, 0, 5'd10, 0, "pp_prime");
        for (int i = 0; i < 10; i++) begin
            step(1, 32'(i * 3), 32'(i), i[0], 5'(11 + i), 1, "push_pop");
        end
        check("pp_occ", o_occ, 2'd1);
        check("pp_rd",  o_rd, 5'd20);

        // Asynchronous reset between edges with two entries stored
        step(1, 32'd1, 32'd1, 0, 5'd6, 0, "prerst_a");
        step(1, 32'd2, 32'd9, 1, 5'd7, 0, "prerst_b");
        check("prerst_occ", o_occ, 2'd2);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_occ",      o_occ, 2'd0);
        check("arst_in_ready", o_in_ready, 1'b1);
        check("arst_valid",    o_out_valid, 1'b0);
        check("arst_result",   o_result, 32'd0);
        check("arst_rd",       o_rd, '0);
        check("arst_flags",    {o_zero, o_neg, o_carry, o_ovf}, 4'b0000);
        check("arst_nf_result", z_result, 32'd0);
        #3;
        rst = 1'b0;
        step(1, 32'h1234_5678, 32'h1111_1111, 1, 5'd9, 0, "post_rst");
        check("post_rst_rd", o_rd, 5'd9);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), rand_word(), rand_word(),
                 $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                 (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 "rand");
        end
        check_outputs("final");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
